// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: opcode encoding produced by the controller
// and default latencies used by the E-stage mult/div unit.
package mips_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage mult/div bundle: the pipeline (master) issues operations and reads
// busy and the architectural HI/LO back from the unit (slave).
interface mult_div_unit_if;

  logic        start;
  logic [2:0]  mult_div_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mult_div_op, A, B, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mult_div_op, A, B, flush,
    output busy, hi, lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: holds HI/LO, computes results at issue
// and commits them after a fixed busy latency.
module mult_div_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_div_unit_if.slave        md
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [31:0]        hi_q, lo_q, hi_tmp, lo_tmp;
  logic [3:0]         cnt;
  logic               busy_q;
  logic               accept;
  logic               div_zero;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor, quot_s, rem_s, quot_u, rem_u;

  assign accept   = md.start & ~md.flush & ~busy_q;
  assign div_zero = (md.B == 32'd0);

  // Divisor is forced to 1 on divide-by-zero so the operators never see zero;
  // the result is discarded in that case. The one signed overflow case is pinned.
  always_comb begin
    prod_s  = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    prod_u  = {32'd0, md.A} * {32'd0, md.B};
    divisor = div_zero ? 32'd1 : md.B;
    if (md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = $unsigned($signed(md.A) / $signed(divisor));
      rem_s  = $unsigned($signed(md.A) % $signed(divisor));
    end
    quot_u = md.A / divisor;
    rem_u  = md.A % divisor;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
      cnt    <= 4'd0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        hi_q   <= hi_tmp;
        lo_q   <= lo_tmp;
        busy_q <= 1'b0;
      end
    end else if (accept) begin
      case (md.mult_div_op)
        MD_MULT: begin
          {hi_tmp, lo_tmp} <= prod_s;
          busy_q           <= 1'b1;
          cnt              <= MULT_LOAD;
        end
        MD_MULTU: begin
          {hi_tmp, lo_tmp} <= prod_u;
          busy_q           <= 1'b1;
          cnt              <= MULT_LOAD;
        end
        // On divide-by-zero the pending result is the current HI/LO, which
        // cannot change while busy, so completion leaves them untouched.
        MD_DIV: begin
          hi_tmp <= div_zero ? hi_q : rem_s;
          lo_tmp <= div_zero ? lo_q : quot_s;
          busy_q <= 1'b1;
          cnt    <= DIV_LOAD;
        end
        MD_DIVU: begin
          hi_tmp <= div_zero ? hi_q : rem_u;
          lo_tmp <= div_zero ? lo_q : quot_u;
          busy_q <= 1'b1;
          cnt    <= DIV_LOAD;
        end
        MD_MTHI: hi_q <= md.A;
        MD_MTLO: lo_q <= md.A;
        default: ;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit of the P7 five-stage MIPS pipeline. Sits directly downstream of the D/E pipeline register. Consumes the E-stage start strobe, 3-bit multiply/divide opcode and forwarded rs/rt operands. Holds the architectural HI/LO registers, models fixed multi-cycle latency with a busy flag for the hazard unit, and supplies HI/LO to the E-stage result mux for mfhi/mflo.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  E-stage strobe; instruction is mult/multu/div/divu/mthi/mtlo this cycle
- mult_div_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved (no-op)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- flush  in  1  exception/eret taken this cycle; E-stage instruction must not commit
- busy  out  1  multi-cycle operation in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Registered state: hi, lo, hi_tmp, lo_tmp, cnt (4 bits), busy. All reset to 0 asynchronously.
- Accepted start is defined as start & ~flush & ~busy. If busy=1 or flush=1, start is ignored entirely.
- Accepted mthi: hi <= A. Accepted mtlo: lo <= A. No busy cycle.
- Accepted mult: {hi_tmp,lo_tmp} <= signed 64-bit A*B. multu does the same with unsigned operands.
- Accepted div: lo_tmp <= A/B and hi_tmp <= A%B, signed, truncating toward zero, remainder takes sign of dividend. divu is unsigned.
- On accepted mult/multu: busy <= 1 and cnt <= MULT_CYCLES-1. On div/divu: busy <= 1 and cnt <= DIV_CYCLES-1.
- While busy: if cnt != 0, cnt decrements. If cnt == 0, then hi <= hi_tmp, lo <= lo_tmp and busy <= 0.
- Division by zero (B=0 on div/divu): hi/lo stay unchanged at completion. Busy still lasts the full DIV_CYCLES.
- div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Reserved opcodes with start=1: no state change, busy stays low.
- flush never cancels an in-flight operation; that instruction already committed past M. flush only suppresses the operation sampled in the same cycle.
- reset mid-operation: busy=0, cnt=0, hi=lo=0 immediately. The pending result is discarded.
- hi/lo are driven straight from registers. No bypass of the in-flight result.
- The hazard unit stalls D on busy | start for any multiply/divide-class instruction. This block does not generate the stall itself.

## Timing
- Edge k samples an accepted mult. busy is high during cycles k+1 … k+5. At edge k+5, hi/lo update and busy falls. The new value is visible from cycle k+6 on (after edge k+5).
- div: busy high during cycles k+1 … k+10. Update occurs at edge k+10.
- mthi/mtlo: write at edge k. Visible the cycle after.
- Back-to-back: a start sampled at the same edge where busy falls is ignored, because busy was 1 at that edge. Next acceptance can happen at edge k+6 (mult).
- Output reset values: busy=0, hi=0, lo=0.

## Structure
- Shared package `mips_defs`:
  - MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO opcode constants
  - MULT_CYCLES and DIV_CYCLES defaults
- These constants are shared with the controller, which produces mult_div_op.
- Single module, no sub-module. Arithmetic uses the `*`, `/` and `%` operators on $signed/unsigned 32-bit operands with 64-bit product width.

## Test plan
- After reset: busy=0, hi=lo=0. Assert reset mid-div: busy=0 and hi=lo=0 at once, with no later update.
- mult A=0xFFFFFFFF, B=2 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu → hi=0x00000001, lo=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → busy exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 → lo=3, hi=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → hi/lo visible the next cycle each, busy never rises. A mult issued with flush=1 → no busy, hi/lo unchanged.
- divu B=0 after mtlo 0x55 → busy 10 cycles, lo stays 0x55. mult start held while busy → ignored, only the first result commits.
- flush asserted during an in-flight mult → result still commits on schedule.
